// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multicycle controller and the shared
// memory port.
//   mem_req   : request valid (controller -> memory)
//   mem_write : write qualifier for mem_req (controller -> memory)
//   mem_ready : memory completes the current request this cycle (memory -> controller)
// Modports: master = controller side, slave = memory side.
interface multicycle_control_if;
  logic mem_req;
  logic mem_write;
  logic mem_ready;

  modport master (output mem_req, output mem_write, input mem_ready);
  modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing RV32I LW/SW/R/I/BEQ/JAL over a
// shared memory port, with ALU decoder and memory-wait watchdog.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   mem                : memory handshake (master modport)
//   op_code_i/func3_i/func7_i/zero_i : instruction fields, ALU zero flag
//   adr_src_o, ir_write_o, pc_update_o, reg_write_o, result_src_o,
//   alu_src_a_o, alu_src_b_o, imm_type_o, alu_control_o : datapath control
//   illegal_instr_o, mem_err_o, state_dbg_o : status
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into ERROR
// with a sticky illegal_instr_o.
//
// state    | meaning
// FETCH    | fetch instruction at PC, PC <= PC+4 on completion
// DECODE   | decode opcode, precompute branch target
// MEMADR   | compute load/store address
// MEMREAD  | load data read, wait for memory
// MEMWB    | write load data to register file
// MEMWRITE | store data write, wait for memory
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to register file
// BEQ      | compare, branch if zero
// JAL      | jump, compute link address
// ERROR    | watchdog timeout or trapped opcode, sticky until rst
module multicycle_control #(
  parameter int ALU_CTRL_W  = 3,
  parameter int IMM_TYPE_W  = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_control_if.master    mem,
  input  logic [6:0]              op_code_i,
  input  logic [2:0]              func3_i,
  input  logic [6:0]              func7_i,
  input  logic                    zero_i,
  output logic                    adr_src_o,
  output logic                    ir_write_o,
  output logic                    pc_update_o,
  output logic                    reg_write_o,
  output logic [1:0]              result_src_o,
  output logic [1:0]              alu_src_a_o,
  output logic [1:0]              alu_src_b_o,
  output logic [IMM_TYPE_W-1:0]   imm_type_o,
  output logic [ALU_CTRL_W-1:0]   alu_control_o,
  output logic                    illegal_instr_o,
  output logic                    mem_err_o,
  output logic [3:0]              state_dbg_o
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10, S_ERROR = 4'd11
  } state_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_FUNC} alu_op_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             mem_err_q, mem_err_d;
  logic             trap_q, trap_d;
  alu_op_t          alu_op;
  logic             mem_req_c, mem_write_c, ir_write_c, pc_update_c, reg_write_c;
  logic             illegal_c;
  logic             wait_last;
  logic             unused_func7;

  assign unused_func7 = ^{func7_i[6], func7_i[4:0]};

  // The cycle in which one more low mem_ready would exceed the allowed wait.
  assign wait_last = (MEM_TIMEOUT != 0) && (wdog_q == WDOG_LAST);

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_update_c  = 1'b0;
    reg_write_c  = 1'b0;
    adr_src_o    = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op       = OP_ADD;
    illegal_c    = 1'b0;
    mem_err_d    = mem_err_q;
    trap_d       = trap_q;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_c   = mem.mem_ready;
        pc_update_c  = mem.mem_ready;
        if (mem.mem_ready) state_d = S_DECODE;
        else if (wait_last) begin
          state_d   = S_ERROR;
          mem_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_code_i)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_RTYPE:           state_d = S_EXECR;
          OPC_ITYPE:           state_d = S_EXECI;
          OPC_BRANCH:          state_d = S_BEQ;
          OPC_JAL:             state_d = S_JAL;
          default: begin
            illegal_c = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            trap_d  = 1'b1;
            state_d = S_ERROR;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = (op_code_i == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_o = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
        else if (wait_last) begin
          state_d   = S_ERROR;
          mem_err_d = 1'b1;
        end
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_o   = 1'b1;
        if (mem.mem_ready) state_d = S_FETCH;
        else if (wait_last) begin
          state_d   = S_ERROR;
          mem_err_d = 1'b1;
        end
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_op      = OP_FUNC;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op      = OP_FUNC;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_op      = OP_SUB;
        pc_update_c = zero_i;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_update_c = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_FETCH;
    endcase

    // Counter restarts whenever the state changes, so it is zero on entry
    // to every memory-waiting state.
    wdog_d = wdog_q;
    if (state_d != state_q) wdog_d = '0;
    else if (mem_req_c && !mem.mem_ready && MEM_TIMEOUT != 0) wdog_d = wdog_q + 1'b1;
  end

  always_comb begin
    alu_control_o = ALU_CTRL_W'(3'b000);
    case (alu_op)
      OP_SUB:  alu_control_o = ALU_CTRL_W'(3'b001);
      OP_FUNC: begin
        case (func3_i)
          3'b000:  alu_control_o = (op_code_i[5] && func7_i[5]) ? ALU_CTRL_W'(3'b001)
                                                                 : ALU_CTRL_W'(3'b000);
          3'b010:  alu_control_o = ALU_CTRL_W'(3'b101);
          3'b100:  alu_control_o = ALU_CTRL_W'(3'b100);
          3'b110:  alu_control_o = ALU_CTRL_W'(3'b011);
          3'b111:  alu_control_o = ALU_CTRL_W'(3'b010);
          default: alu_control_o = ALU_CTRL_W'(3'b111);
        endcase
      end
      default: alu_control_o = ALU_CTRL_W'(3'b000);
    endcase
  end

  always_comb begin
    case (op_code_i)
      OPC_STORE:  imm_type_o = IMM_TYPE_W'(3'b001);
      OPC_BRANCH: imm_type_o = IMM_TYPE_W'(3'b010);
      OPC_JAL:    imm_type_o = IMM_TYPE_W'(3'b011);
      default:    imm_type_o = IMM_TYPE_W'(3'b000);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wdog_q    <= '0;
      mem_err_q <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      mem_err_q <= mem_err_d;
      trap_q    <= trap_d;
    end
  end

  // Strobes are held off for the whole reset cycle.
  assign mem.mem_req     = mem_req_c & ~rst;
  assign mem.mem_write   = mem_write_c & ~rst;
  assign ir_write_o      = ir_write_c & ~rst;
  assign pc_update_o     = pc_update_c & ~rst;
  assign reg_write_o     = reg_write_c & ~rst;
  assign illegal_instr_o = illegal_c | trap_q;
  assign mem_err_o       = mem_err_q;
  assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (MEM_TIMEOUT = 4).
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op_code;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       adr_src, ir_write, pc_update, reg_write, illegal_instr, mem_err;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_type, alu_control;
  logic [3:0] state_dbg;
  int         n_chk  = 0;
  int         n_pass = 0;

  multicycle_control_if bus ();

  multicycle_control #(.ALU_CTRL_W(3), .IMM_TYPE_W(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem(bus.master),
    .op_code_i(op_code), .func3_i(func3), .func7_i(func7), .zero_i(zero),
    .adr_src_o(adr_src), .ir_write_o(ir_write), .pc_update_o(pc_update),
    .reg_write_o(reg_write), .result_src_o(result_src), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .imm_type_o(imm_type), .alu_control_o(alu_control),
    .illegal_instr_o(illegal_instr), .mem_err_o(mem_err), .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; op_code = 7'b0000011; func3 = 3'b000; func7 = 7'b0; zero = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    // reset cycle: FETCH state but every strobe gated
    check("rst_state", state_dbg, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_ir_write", ir_write, 0);
    check("rst_pc_update", pc_update, 0);
    check("rst_mem_err", mem_err, 0);
    rst = 1'b0; settle();
    check("fetch_req_after_rst", bus.mem_req, 1);

    // LW: 0,1,2,3,4,0
    check("lw_fetch_irw", ir_write, 1);
    check("lw_fetch_srcb", alu_src_b, 2);
    check("lw_fetch_res", result_src, 2);
    tick(); check("lw_decode", state_dbg, 1);
    check("lw_decode_srca", alu_src_a, 1);
    check("lw_decode_srcb", alu_src_b, 1);
    check("lw_imm", imm_type, 0);
    tick(); check("lw_memadr", state_dbg, 2);
    check("lw_memadr_srca", alu_src_a, 2);
    tick(); check("lw_memread", state_dbg, 3);
    check("lw_memread_req", bus.mem_req, 1);
    check("lw_memread_adr", adr_src, 1);
    check("lw_memread_rw", reg_write, 0);
    tick(); check("lw_memwb", state_dbg, 4);
    check("lw_memwb_rw", reg_write, 1);
    check("lw_memwb_res", result_src, 1);
    tick(); check("lw_back_fetch", state_dbg, 0);

    // SW with three wait cycles in MEMWRITE
    op_code = 7'b0100011; settle();
    tick(); check("sw_decode", state_dbg, 1);
    check("sw_imm", imm_type, 1);
    tick(); check("sw_memadr", state_dbg, 2);
    tick(); bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ready = 1'b1;
      settle();
      check($sformatf("sw_wait%0d_state", i), state_dbg, 5);
      check($sformatf("sw_wait%0d_req", i), bus.mem_req, 1);
      check($sformatf("sw_wait%0d_wr", i), bus.mem_write, 1);
      tick();
    end
    check("sw_back_fetch", state_dbg, 0);
    check("sw_fetch_wr", bus.mem_write, 0);

    // R-type ALU decode
    op_code = 7'b0110011; func3 = 3'b000; func7 = 7'b0100000; settle();
    tick(); tick(); check("r_execr", state_dbg, 6);
    check("r_sub", alu_control, 1);
    check("r_srcb", alu_src_b, 0);
    func7 = 7'b0; settle(); check("r_add", alu_control, 0);
    func3 = 3'b111; settle(); check("r_and", alu_control, 2);
    func3 = 3'b110; settle(); check("r_or", alu_control, 3);
    func3 = 3'b100; settle(); check("r_xor", alu_control, 4);
    func3 = 3'b010; settle(); check("r_slt", alu_control, 5);
    func3 = 3'b001; settle(); check("r_other", alu_control, 7);
    tick(); check("r_aluwb", state_dbg, 8);
    check("r_aluwb_rw", reg_write, 1);
    check("r_aluwb_res", result_src, 0);
    check("r_aluwb_add", alu_control, 0);
    tick(); check("r_back_fetch", state_dbg, 0);

    // I-type: func7[5] set but op_code[5]=0 keeps add
    op_code = 7'b0010011; func3 = 3'b000; func7 = 7'b0100000; settle();
    tick(); tick(); check("i_execi", state_dbg, 7);
    check("i_srcb", alu_src_b, 1);
    check("i_add", alu_control, 0);
    tick(); tick(); check("i_back_fetch", state_dbg, 0);

    // BEQ taken / not taken
    op_code = 7'b1100011; zero = 1'b1; settle();
    tick(); check("beq_imm", imm_type, 2);
    tick(); check("beq_state", state_dbg, 9);
    check("beq_taken", pc_update, 1);
    check("beq_sub", alu_control, 1);
    zero = 1'b0; settle(); check("beq_not_taken", pc_update, 0);
    tick(); check("beq_back_fetch", state_dbg, 0);

    // JAL, with fetch waiting 3 cycles and ready arriving in the last allowed one
    op_code = 7'b1101111; bus.mem_ready = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("jal_fw%0d_irw", i), ir_write, 0);
      tick();
      check($sformatf("jal_fw%0d_state", i), state_dbg, 0);
    end
    bus.mem_ready = 1'b1; settle();
    tick(); check("jal_ready_priority", state_dbg, 1);
    check("jal_imm", imm_type, 3);
    tick(); check("jal_state", state_dbg, 10);
    check("jal_pcu", pc_update, 1);
    tick(); check("jal_aluwb", state_dbg, 8);
    check("jal_rw", reg_write, 1);
    tick(); check("jal_back_fetch", state_dbg, 0);

    // Illegal opcode
    op_code = 7'b1111111; settle();
    tick(); check("ill_decode", state_dbg, 1);
    check("ill_pulse", illegal_instr, 1);
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill_trap_state", state_dbg, 11);
    check("ill_sticky", illegal_instr, 1);
    check("ill_mem_err", mem_err, 0);
    rst = 1'b1; tick(); rst = 1'b0; settle();
`else
    check("ill_state", state_dbg, 0);
    check("ill_cleared", illegal_instr, 0);
`endif

    // Watchdog: fetch never completes
    op_code = 7'b0000011; bus.mem_ready = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wd_wait%0d_state", i), state_dbg, 0);
      tick();
    end
    check("wd_error", state_dbg, 11);
    check("wd_mem_err", mem_err, 1);
    check("wd_no_req", bus.mem_req, 0);
    bus.mem_ready = 1'b1; tick(); tick();
    check("wd_sticky_state", state_dbg, 11);
    check("wd_sticky_err", mem_err, 1);
    rst = 1'b1; tick();
    check("wd_rst_state", state_dbg, 0);
    check("wd_rst_err", mem_err, 0);
    check("wd_rst_req", bus.mem_req, 0);
    rst = 1'b0; settle();
    check("wd_rst_release_req", bus.mem_req, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle successor to the single-cycle LW/SW decoder. It is a Moore-style FSM that sequences RV32I instructions (LW, SW, R-type, I-type ALU, BEQ, JAL) over several cycles through one shared memory port, using a valid/ready memory handshake. It contains a main FSM, a combinational ALU decoder, and a memory-wait watchdog counter. It sits between the instruction register and the multicycle datapath: mux selects, register-file write enable, PC/IR enables, memory request.

Parameters:
ALU_CTRL_W, 3, width of alu_control.
IMM_TYPE_W, 3, width of imm_type.
MEM_TIMEOUT, 16, maximum consecutive wait cycles with mem_ready low before the block enters ERROR. A value of 0 disables the watchdog.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
op_code  in  7  instruction opcode from the IR.
func3  in  3  instruction func3.
func7  in  7  instruction func7 (only bit 5 is used).
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current request this cycle.
mem_req  out  1  memory request valid.
mem_write  out  1  write qualifier for mem_req.
adr_src  out  1  address select: 0 = PC, 1 = ALUOut.
ir_write  out  1  IR/OldPC load enable.
pc_update  out  1  PC load enable.
reg_write  out  1  register-file write enable.
result_src  out  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALU result.
alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
imm_type  out  IMM_TYPE_W  immediate format: I = 000, S = 001, B = 010, J = 011.
alu_control  out  ALU_CTRL_W  ALU operation code.
illegal_instr  out  1  unsupported opcode seen in DECODE (sticky only with the optional feature).
mem_err  out  1  sticky watchdog timeout flag.
state_dbg  out  4  current state encoding.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, ERROR=11.
- Reset: on a clk edge with rst=1, state <= FETCH, watchdog counter <= 0, mem_err <= 0, trap flag <= 0.
- While rst=1, mem_req, mem_write, ir_write, pc_update and reg_write are forced to 0.
- The first fetch request is issued in the cycle after rst is released.
- Defaults in every state: all strobes 0, all selects 00, alu_op add.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
  - ir_write = pc_update = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, add (precomputes the branch target).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other opcode: illegal_instr=1 for this cycle, then -> FETCH (instruction is a NOP).
- MEMADR: alu_src_a=10, alu_src_b=01, add. LW -> MEMREAD; SW -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1, then -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Waits for mem_ready, then -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=func, then -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=func, then -> ALUWB.
- ALUWB: result_src=00, reg_write=1, then -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_update=zero, then -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_update=1, then -> ALUWB (rd <= PC+4).
- imm_type is decoded combinationally from op_code in every state: store -> S, branch -> B, JAL -> J, all others -> I.
- ALU decoder: add=000, sub=001, and=010, or=011, xor=100, slt=101.
  - alu_op=func with func3 = 000: sub if op_code[5] & func7[5], otherwise add.
  - func3 = 010 -> slt; 100 -> xor; 110 -> or; 111 -> and; any other func3 -> 111.
- Watchdog:
  - The counter clears on entry to FETCH, MEMREAD or MEMWRITE.
  - It increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, the next state is ERROR.
  - A mem_ready arriving in that same cycle has priority: the transfer completes normally.
- ERROR: all strobes 0, mem_err=1. Sticky until rst.
- Reset mid-operation aborts the instruction; no strobe is asserted in the rst cycle.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE moves the FSM to ERROR; illegal_instr stays 1 until rst; mem_err is unaffected.
- Undefined: illegal_instr is a single-cycle pulse and the FSM returns to FETCH.

Test Plan:
1. Reset, then LW (op 0000011) with mem_ready=1 always -> states 0,1,2,3,4,0. reg_write=1 only in state 4 with result_src=01. No strobes in the rst cycle.
2. SW (op 0100011) with mem_ready held low 3 cycles in MEMWRITE -> mem_req=1 and mem_write=1 for 4 cycles, then FETCH. imm_type=001.
3. R-type op 0110011, func3=000, func7=0100000 -> alu_control=001 in EXECR. Same with func7=0 -> 000. func3=111 -> 010.
4. BEQ: zero=1 -> pc_update=1 in state 9. zero=0 -> pc_update=0. Both return to FETCH. imm_type=010.
5. JAL op 1101111 -> states 0,1,10,8,0. pc_update=1 in JAL. reg_write=1 in ALUWB. imm_type=011.
6. MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> ERROR (11) after 4 wait cycles, mem_err=1 until rst. Opcode 1111111 -> illegal_instr pulse and FETCH (trap variant: ERROR).
